serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial N-bit adder controller: time-multiplexes one full_adder instance over NUM_BITS
//   operand bits, LSB first, one bit per clock. Accepts an operand pair on a start pulse and
//   reports a registered N-bit sum plus carry-out with a one-cycle done strobe.
//   Sits between a host/test sequencer and the single-bit adder datapath.
// PARAMETERS
//   NUM_BITS  8  operand/sum width in bits (legal range 2..32)
// PORTS
//   clk        in   1         system clock, rising edge
//   n_rst      in   1         asynchronous active-low reset
//   start      in   1         request; sampled only in IDLE or DONE
//   a          in   NUM_BITS  operand A, captured on accepted start
//   b          in   NUM_BITS  operand B, captured on accepted start
//   carry_in   in   1         initial carry, captured on accepted start
//   busy       out  1         high while in SHIFT
//   done       out  1         one-cycle strobe: sum/carry_out just became valid
//   sum        out  NUM_BITS  registered result, held until next completion
//   carry_out  out  1         registered final carry, held with sum
// BEHAVIOUR
//   - Reset (n_rst low, async): state=IDLE; busy=0, done=0, sum=0, carry_out=0;
//     operand shift regs, carry reg and bit counter cleared.
//   - FSM states IDLE, SHIFT, DONE; busy and done are Moore outputs (SHIFT, DONE resp.).
//   - IDLE: start=1 at edge E0 -> load a_sr<=a, b_sr<=b, c_reg<=carry_in, cnt<=0, ps_sr<=0;
//     next=SHIFT. start=0 -> stay.
//   - SHIFT, each edge: full_adder inputs (a_sr[0], b_sr[0], c_reg);
//     ps_sr <= {fa_sum, ps_sr[NUM_BITS-1:1]}; a_sr, b_sr shift right 1; c_reg <= fa_cout;
//     cnt <= cnt+1. start ignored.
//   - Last bit (cnt==NUM_BITS-1 at the edge): sum <= {fa_sum, ps_sr[NUM_BITS-1:1]},
//     carry_out <= fa_cout, next=DONE.
//   - Latency: done high exactly NUM_BITS edges after the start-sampling edge E0,
//     for exactly one cycle.
//   - DONE: start=1 -> accept new operands exactly as in IDLE (back-to-back), next=SHIFT;
//     else next=IDLE.
//   - sum/carry_out change only on the SHIFT->DONE edge; stable in IDLE, SHIFT and DONE otherwise.
//   - Arithmetic: {carry_out,sum} == a + b + carry_in, modulo 2^(NUM_BITS+1); no overflow flag.
//   - Operand inputs may change freely after the accepting edge; only captured copies are used.
//   - Reset mid-SHIFT: immediate abort to IDLE with all outputs 0; no done strobe for the
//     aborted operation.
//   - Unreachable state encodings recover to IDLE.
//   - cnt width = $clog2(NUM_BITS); never exceeds NUM_BITS-1.
// STRUCTURE
//   - Shared package serial_adder_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t.
//   - Single sub-module: one full_adder instance (a, b, carry_in -> sum, carry_out),
//     combinational, driven from a_sr[0], b_sr[0], c_reg.
//   - Remaining logic in this module: state register plus next-state logic, shift registers,
//     bit counter, output registers.
// TESTING (NUM_BITS=8)
//   1. Reset held 3 cycles, then released -> busy=0, done=0, sum=8'h00, carry_out=0.
//   2. a=8'h5A, b=8'h3C, carry_in=0, start 1 cycle -> busy for 8 cycles;
//      done 8 edges after start; sum=8'h96, carry_out=0.
//   3. a=8'hFF, b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1.
//      Then a=8'hFF, b=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1.
//   4. start re-pulsed with a=8'h11 at cycle 3 of SHIFT -> ignored; original result delivered;
//      only one done strobe.
//   5. start held high through DONE with new a=8'h01, b=8'h02 -> SHIFT re-entered with no
//      IDLE cycle; second done 8 edges later with sum=8'h03.
//   6. n_rst pulsed low at SHIFT cycle 4 -> outputs 0 asynchronously; no done;
//      next start computes a fresh, correct sum.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit combinational full adder; the one datapath cell the controller reuses per bit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial NUM_BITS adder: one full adder time-multiplexed LSB first, one bit per clock.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out
);

    localparam int CW = $clog2(NUM_BITS);
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

    sa_state_t             state_q, state_d;
    logic [NUM_BITS-1:0]   a_sr_q, a_sr_d;
    logic [NUM_BITS-1:0]   b_sr_q, b_sr_d;
    logic                  c_q, c_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    // Partial sum keeps only the upper NUM_BITS-1 bits; the final bit goes straight to sum.
    logic [NUM_BITS-2:0]   ps_q, ps_d;
    logic [NUM_BITS-1:0]   sum_q, sum_d;
    logic                  cout_q, cout_d;

    logic                  fa_sum, fa_cout;
    logic [NUM_BITS-1:0]   ps_next;

    full_adder u_fa (
        .a         (a_sr_q[0]),
        .b         (b_sr_q[0]),
        .carry_in  (c_q),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    assign ps_next = {fa_sum, ps_q};

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = carry_in;
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                c_d    = fa_cout;
                ps_d   = ps_next[NUM_BITS-1:1];
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    sum_d   = ps_next;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed plus randomized checks of the serial adder against an arithmetic reference.
module tb_serial_adder_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy, done, carry_out;
    logic [N-1:0] sum;

    int checks = 0;
    int errors = 0;
    logic [N:0] prev_res = '0;   // {carry_out,sum} the outputs must hold until next completion

    serial_adder_ctrl #(.NUM_BITS(N)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic c);
        return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge (E0); operand inputs are scrambled right after capture.
    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; carry_in = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); carry_in = 1'($urandom);
        check("busy_after_start", busy, 1);
    endtask

    // Returns at the negedge where done is high; n counts edges after E0.
    task automatic wait_result(input logic [N:0] exp, input int repulse_at, input string tag);
        int n;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) break;
            if (n == repulse_at) begin start = 1'b1; a = 8'h11; end
            else if (repulse_at > 0 && n == repulse_at + 1) start = 1'b0;
            if (!busy || {carry_out, sum} !== prev_res) begin
                check({tag, "_busy_hold"}, {busy, carry_out, sum}, {1'b1, prev_res});
            end
        end
        check({tag, "_latency"}, n, N);
        check({tag, "_sum"}, {carry_out, sum}, exp);
        prev_res = exp;
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, "_single_done"}, {done, busy}, 2'b00);
        check({tag, "_hold"}, {carry_out, sum}, prev_res);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc;
        int           dcount;

        // 1. reset
        repeat (3) @(negedge clk);
        check("reset_during", {busy, done, carry_out, sum}, '0);
        n_rst = 1'b1;
        @(negedge clk);
        check("reset_after", {busy, done, carry_out, sum}, '0);

        // 2, 3. directed operands
        issue(8'h5A, 8'h3C, 1'b0); wait_result(model(8'h5A, 8'h3C, 1'b0), 0, "t2");
        check("t2_const", {carry_out, sum}, 9'h096);
        after_done("t2");
        issue(8'hFF, 8'h01, 1'b0); wait_result(model(8'hFF, 8'h01, 1'b0), 0, "t3a");
        check("t3a_const", {carry_out, sum}, 9'h100);
        after_done("t3a");
        issue(8'hFF, 8'hFF, 1'b1); wait_result(model(8'hFF, 8'hFF, 1'b1), 0, "t3b");
        check("t3b_const", {carry_out, sum}, 9'h1FF);
        after_done("t3b");

        // 4. start re-pulsed mid-SHIFT is ignored
        issue(8'h22, 8'h33, 1'b0); wait_result(model(8'h22, 8'h33, 1'b0), 3, "t4");
        dcount = 0;
        repeat (12) begin @(negedge clk); if (done || busy) dcount++; end
        check("t4_no_extra_op", dcount, 0);

        // 5. back-to-back: start held through DONE
        issue(8'h40, 8'h07, 1'b1); wait_result(model(8'h40, 8'h07, 1'b1), 0, "t5a");
        a = 8'h01; b = 8'h02; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_no_idle", {busy, done}, 2'b10);
        wait_result(model(8'h01, 8'h02, 1'b0), 0, "t5b");
        check("t5_const", {carry_out, sum}, 9'h003);
        after_done("t5b");

        // 6. async reset mid-SHIFT
        issue(8'hC3, 8'h5E, 1'b1);
        repeat (4) @(negedge clk);
        #2 n_rst = 1'b0;
        #1 check("t6_async_clear", {busy, done, carry_out, sum}, '0);
        prev_res = '0;
        @(negedge clk);
        n_rst = 1'b1;
        dcount = 0;
        repeat (12) begin @(negedge clk); if (done || busy) dcount++; end
        check("t6_no_done", dcount, 0);
        issue(8'h9C, 8'hA7, 1'b0); wait_result(model(8'h9C, 8'hA7, 1'b0), 0, "t6_fresh");
        after_done("t6_fresh");

        // randomized operands against the arithmetic model
        repeat (12) begin
            ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
            issue(ra, rb, rc); wait_result(model(ra, rb, rc), 0, "rand");
            if ($urandom_range(1, 0) == 1) after_done("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
